ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard, for example 0xED (set LEDs) followed by the LED mask, or 0xFF (reset). It drives the open-drain PS/2 clock and data lines through active-high pull-low enables and filters the line inputs the same way the keyboard receiver does. It sits beside the keyboard receiver on the same PS2C/PS2D pads; the top level combines the enables into tri-state pads.

Parameters:
INHIBIT_CYCLES, 2500, clock-low inhibit time in clk25 cycles (100 us at 25 MHz).
SETUP_CYCLES, 25, cycles with clock and data both held low before clock release (1 us).
EDGE_TIMEOUT, 375000, maximum cycles to wait for each device clock falling edge (15 ms).
IDLE_TIMEOUT, 50000, maximum cycles to wait for bus idle after ACK (2 ms).

Ports:
clk25  in  1  system clock, 25 MHz
rst  in  1  synchronous reset, active-high
send  in  1  request; sampled only when busy=0
din  in  8  command byte; latched on the cycle send is accepted
PS2C  in  1  raw PS/2 clock pad input
PS2D  in  1  raw PS/2 data pad input
ps2c_oe  out  1  1 = pull clock low; 0 = release
ps2d_oe  out  1  1 = pull data low; 0 = release
busy  out  1  transfer in progress
done  out  1  one-cycle pulse: byte sent and ACKed
err  out  1  one-cycle pulse: timeout or NACK

Behaviour:
- Reset values: ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0, state IDLE, all counters 0. The filters reset to 8'hFF and the filtered lines reset to 1.
- Input filter: each line goes through an 8-bit shift register. The filtered value goes to 1 when all 8 samples are 1 and to 0 when all 8 are 0; otherwise it holds. A falling edge of the filtered clock (fall) is a registered 1-cycle strobe.
- Accept: when send=1 and busy=0, latch din and compute par = ~^din (odd parity). Next cycle busy=1 and state is INHIBIT. While busy=1, send is ignored.
- INHIBIT: ps2c_oe=1, ps2d_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: ps2c_oe=1, ps2d_oe=1 for SETUP_CYCLES cycles, then go to XFER with bit index 0 and ps2c_oe=0. ps2d_oe stays 1; this is the start bit.
- XFER: state changes only on fall.
  - Falls 1–8 drive data bit idx-1, LSB first: ps2d_oe = ~bit.
  - Fall 9 drives parity: ps2d_oe = ~par.
  - Fall 10 releases data for the stop bit: ps2d_oe=0.
  - Fall 11 samples filtered data for the ACK. Data=0 means ACK and goes to WAIT_IDLE. Data=1 means NACK: set an error flag, then go to WAIT_IDLE.
- The edge timer resets on entry to XFER and on every fall. If it reaches EDGE_TIMEOUT: release both lines, pulse err, and go to IDLE with busy=0.
- WAIT_IDLE: both lines released. Wait until filtered clock=1 and filtered data=1 in the same cycle. Then pulse done (no error flag) or err (error flag), and the next cycle busy=0. If IDLE_TIMEOUT expires first, pulse err and go to IDLE.
- done and err are never asserted together. busy falls on the cycle after the done/err pulse.
- Back-to-back: send may be accepted on the first cycle busy=0.
- rst mid-transfer: lines are released on the next clk25 edge and no done/err pulse is produced. The device then times out on its own.
- The line ports are never driven high: only the enables exist.

Test Plan:
- Keyboard model clocks at 12.5 kHz and ACKs; send din=0xED. Expected: ps2c_oe low for 2500 cycles, then both lines low for 25 cycles. Bits sampled on device rising edges: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK is seen, then exactly one done pulse and busy=0.
- Parity check: send din=0x00, then din=0x01 back-to-back (second send on the first cycle busy=0). Expected parity 1, then parity 0. Two done pulses, no err.
- NACK: the model leaves data high on the 11th clock with din=0xFF. Expected: err pulse once the bus is idle, no done, busy cleared.
- Timeout: the model never clocks. Expected: err pulse exactly EDGE_TIMEOUT cycles after clock release, both enables 0, busy=0.
- Busy and reset: pulse send with din=0xAA during the transfer of 0x55. Expected: ignored, and the 0x55 frame is correct. Then assert rst after the 4th falling edge. Expected: enables 0 and busy=0 on the next cycle, no done/err pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit the bus, request to send, shift one
// byte plus odd parity out on device clock falls, then check the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int SETUP_CYCLES   = 25,
   parameter int EDGE_TIMEOUT   = 375000,
   parameter int IDLE_TIMEOUT   = 50000
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       send,
   input  logic [7:0] din,
   input  logic       PS2C,
   input  logic       PS2D,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int MAX_A   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int MAX_B   = (EDGE_TIMEOUT > IDLE_TIMEOUT) ? EDGE_TIMEOUT : IDLE_TIMEOUT;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] EDGE_LAST    = CW'(EDGE_TIMEOUT - 1);
   localparam logic [CW-1:0] IDLE_LAST    = CW'(IDLE_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, WAIT_IDLE} state_t;

   // Bit 0 is the clock line, bit 1 the data line.
   logic [1:0] line_raw;
   logic [1:0] line_filt;
   assign line_raw = {PS2D, PS2C};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_filt
         logic [7:0] sr_reg;
         logic       filt_reg;
         always_ff @(posedge clk25) begin
            if (rst) begin
               sr_reg   <= 8'hFF;
               filt_reg <= 1'b1;
            end else begin
               sr_reg <= {line_raw[gi], sr_reg[7:1]};
               if (sr_reg == 8'hFF)
                  filt_reg <= 1'b1;
               else if (sr_reg == 8'h00)
                  filt_reg <= 1'b0;
            end
         end
         assign line_filt[gi] = filt_reg;
      end
   endgenerate

   logic clk_prev_reg, fall_reg;
   always_ff @(posedge clk25) begin
      if (rst) begin
         clk_prev_reg <= 1'b1;
         fall_reg     <= 1'b0;
      end else begin
         clk_prev_reg <= line_filt[0];
         fall_reg     <= clk_prev_reg & ~line_filt[0];
      end
   end

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [3:0]    idx_reg, idx_next;
   logic [7:0]    data_reg, data_next;
   logic          par_reg, par_next;
   logic          err_flag_reg, err_flag_next;
   logic          c_oe_reg, c_oe_next;
   logic          d_oe_reg, d_oe_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;

   always_ff @(posedge clk25) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         idx_reg      <= '0;
         data_reg     <= '0;
         par_reg      <= 1'b0;
         err_flag_reg <= 1'b0;
         c_oe_reg     <= 1'b0;
         d_oe_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         idx_reg      <= idx_next;
         data_reg     <= data_next;
         par_reg      <= par_next;
         err_flag_reg <= err_flag_next;
         c_oe_reg     <= c_oe_next;
         d_oe_reg     <= d_oe_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      idx_next      = idx_reg;
      data_next     = data_reg;
      par_next      = par_reg;
      err_flag_next = err_flag_reg;
      c_oe_next     = c_oe_reg;
      d_oe_next     = d_oe_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            // busy_reg is still high on the done/err cycle, so a request then is ignored
            c_oe_next = 1'b0;
            d_oe_next = 1'b0;
            busy_next = 1'b0;
            cnt_next  = '0;
            if (send && !busy_reg) begin
               data_next     = din;
               par_next      = ~^din;
               err_flag_next = 1'b0;
               busy_next     = 1'b1;
               c_oe_next     = 1'b1;
               state_next    = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_reg == INHIBIT_LAST) begin
               cnt_next   = '0;
               d_oe_next  = 1'b1;
               state_next = RTS;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RTS: begin
            if (cnt_reg == SETUP_LAST) begin
               cnt_next   = '0;
               idx_next   = '0;
               c_oe_next  = 1'b0;
               state_next = XFER;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         XFER: begin
            if (fall_reg) begin
               cnt_next = '0;
               idx_next = idx_reg + 4'd1;
               if (idx_reg < 4'd8)
                  d_oe_next = ~data_reg[idx_reg[2:0]];
               else if (idx_reg == 4'd8)
                  d_oe_next = ~par_reg;
               else if (idx_reg == 4'd9)
                  d_oe_next = 1'b0;
               else begin
                  err_flag_next = line_filt[1];
                  state_next    = WAIT_IDLE;
               end
            end else if (cnt_reg == EDGE_LAST) begin
               c_oe_next  = 1'b0;
               d_oe_next  = 1'b0;
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_IDLE: begin
            c_oe_next = 1'b0;
            d_oe_next = 1'b0;
            if (line_filt == 2'b11) begin
               done_next  = ~err_flag_reg;
               err_next   = err_flag_reg;
               state_next = IDLE;
            end else if (cnt_reg == IDLE_LAST) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign ps2c_oe = c_oe_reg;
   assign ps2d_oe = d_oe_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign err     = err_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a keyboard model that clocks
// the frame in, samples bits on its rising edges and answers ACK or NACK.
module tb_ps2_host_tx;
   localparam int INH     = 100;
   localparam int SETUP   = 10;
   localparam int EDGE_TO = 3000;
   localparam int IDLE_TO = 1000;
   localparam int HALF    = 40;

   logic       clk25 = 1'b0;
   logic       rst = 1'b1;
   logic       send = 1'b0;
   logic [7:0] din = 8'h00;
   logic       ps2c_pad, ps2d_pad;
   logic       ps2c_oe, ps2d_oe, busy, done, err;
   logic       dev_c_low = 1'b0;
   logic       dev_d_low = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
   int release_cyc = 0, busy_fall_cyc = 0, inhibit_len = 0, setup_len = 0;
   logic prev_c_oe = 1'b0, prev_busy = 1'b0;

   assign ps2c_pad = ~(ps2c_oe | dev_c_low);
   assign ps2d_pad = ~(ps2d_oe | dev_d_low);

   always #20 clk25 = ~clk25;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .SETUP_CYCLES(SETUP),
      .EDGE_TIMEOUT(EDGE_TO),
      .IDLE_TIMEOUT(IDLE_TO)
   ) dut (
      .clk25(clk25),
      .rst(rst),
      .send(send),
      .din(din),
      .PS2C(ps2c_pad),
      .PS2D(ps2d_pad),
      .ps2c_oe(ps2c_oe),
      .ps2d_oe(ps2d_oe),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always @(posedge clk25) cyc <= cyc + 1;

   always @(negedge clk25) begin
      if (done === 1'b1) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
      if (err === 1'b1) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
      if (ps2c_oe === 1'b1 && ps2d_oe === 1'b0) inhibit_len = inhibit_len + 1;
      if (ps2c_oe === 1'b1 && ps2d_oe === 1'b1) setup_len = setup_len + 1;
      if (prev_c_oe === 1'b1 && ps2c_oe === 1'b0) release_cyc = cyc;
      if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
      prev_c_oe = ps2c_oe;
      prev_busy = busy;
   end

   initial begin
      #(200000 * 40);
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk25);
   endtask

   task automatic wait_not_busy(input int budget);
      int t;
      t = 0;
      while (busy !== 1'b0 && t < budget) begin tick(1); t++; end
      if (busy !== 1'b0) begin
         vectors++; miscompares++;
         $display("FAIL busy_wait: busy=%b after %0d cycles, required 0", busy, budget);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      wait_not_busy(20000);
      din  = b;
      send = 1'b1;
      tick(1);
      send = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_%h: busy=%b, required 1", b, busy);
      end
   endtask

   // Keyboard model: bits[0] is the start bit seen at clock release, bits[i]
   // is data sampled on the rising edge after fall i.
   task automatic device_frame(input bit ack, input int nfalls, input int poke_fall,
                               output logic [10:0] bits);
      int t;
      bits = '0;
      t = 0;
      while (!(ps2c_pad === 1'b1 && ps2d_pad === 1'b0) && t < 5000) begin tick(1); t++; end
      if (t >= 5000) begin
         vectors++; miscompares++;
         $display("FAIL rts_seen: no request-to-send within 5000 cycles, required one");
         return;
      end
      bits[0] = ps2d_pad;
      tick(HALF);
      for (int i = 1; i <= nfalls && i <= 10; i++) begin
         dev_c_low = 1'b1;
         if (i == poke_fall) begin
            din  = 8'hAA;
            send = 1'b1;
            tick(1);
            send = 1'b0;
            tick(HALF - 1);
         end else begin
            tick(HALF);
         end
         dev_c_low = 1'b0;
         bits[i] = ps2d_pad;
         tick(HALF);
      end
      if (nfalls >= 11) begin
         dev_d_low = ack;
         tick(10);
         dev_c_low = 1'b1;
         tick(HALF);
         dev_c_low = 1'b0;
         tick(HALF);
         dev_d_low = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      vectors++;
      if ({ps2c_oe, ps2d_oe, busy, done, err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: {c_oe,d_oe,busy,done,err}=%b, required 00000",
                  {ps2c_oe, ps2d_oe, busy, done, err});
      end
      rst = 1'b0;
      tick(20);
      vectors++;
      if ({ps2c_oe, ps2d_oe, busy} !== 3'b0 || done_cnt + err_cnt !== 0) begin
         miscompares++;
         $display("FAIL idle_after_reset: c_oe=%b d_oe=%b busy=%b pulses=%0d, required 0 0 0 0",
                  ps2c_oe, ps2d_oe, busy, done_cnt + err_cnt);
      end
      $display("reset released, outputs idle");
   endtask

   task automatic test_send_ed();
      logic [10:0] bits;
      int d0, e0, i0, s0;
      d0 = done_cnt; e0 = err_cnt; i0 = inhibit_len; s0 = setup_len;
      send_byte(8'hED);
      device_frame(1'b1, 11, 0, bits);
      wait_not_busy(500);
      tick(2);
      $display("tx ED frame=%b done=%0d err=%0d", bits, done_cnt - d0, err_cnt - e0);
      vectors++;
      if (inhibit_len - i0 !== INH) begin
         miscompares++;
         $display("FAIL ed_inhibit_len: %0d cycles, required %0d", inhibit_len - i0, INH);
      end
      vectors++;
      if (setup_len - s0 !== SETUP) begin
         miscompares++;
         $display("FAIL ed_setup_len: %0d cycles, required %0d", setup_len - s0, SETUP);
      end
      vectors++;
      if (bits !== 11'h7DA) begin
         miscompares++;
         $display("FAIL ed_frame: %b, required %b", bits, 11'h7DA);
      end
      vectors++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
         miscompares++;
         $display("FAIL ed_pulses: done=%0d err=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
      end
      vectors++;
      if (busy_fall_cyc !== done_cyc + 1) begin
         miscompares++;
         $display("FAIL ed_busy_fall: busy fell at %0d, required %0d", busy_fall_cyc, done_cyc + 1);
      end
      vectors++;
      if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
         miscompares++;
         $display("FAIL ed_released: c_oe=%b d_oe=%b, required 0 0", ps2c_oe, ps2d_oe);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] bits_a, bits_b;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h00);
      device_frame(1'b1, 11, 0, bits_a);
      send_byte(8'h01);
      device_frame(1'b1, 11, 0, bits_b);
      wait_not_busy(500);
      tick(2);
      $display("tx 00 frame=%b, tx 01 frame=%b", bits_a, bits_b);
      vectors++;
      if (bits_a !== 11'h600) begin
         miscompares++;
         $display("FAIL b2b_frame_00: %b, required %b", bits_a, 11'h600);
      end
      vectors++;
      if (bits_b !== 11'h402) begin
         miscompares++;
         $display("FAIL b2b_frame_01: %b, required %b", bits_b, 11'h402);
      end
      vectors++;
      if (bits_a[9] !== 1'b1 || bits_b[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_parity: %b %b, required 1 0", bits_a[9], bits_b[9]);
      end
      vectors++;
      if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
         miscompares++;
         $display("FAIL b2b_pulses: done=%0d err=%0d, required 2 0", done_cnt - d0, err_cnt - e0);
      end
   endtask

   task automatic test_nack();
      logic [10:0] bits;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hFF);
      device_frame(1'b0, 11, 0, bits);
      wait_not_busy(500);
      tick(2);
      $display("tx FF frame=%b nack done=%0d err=%0d", bits, done_cnt - d0, err_cnt - e0);
      vectors++;
      if (bits !== 11'h7FE) begin
         miscompares++;
         $display("FAIL nack_frame: %b, required %b", bits, 11'h7FE);
      end
      vectors++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
         miscompares++;
         $display("FAIL nack_pulses: done=%0d err=%0d, required 0 1", done_cnt - d0, err_cnt - e0);
      end
      vectors++;
      if (busy_fall_cyc !== err_cyc + 1) begin
         miscompares++;
         $display("FAIL nack_busy_fall: busy fell at %0d, required %0d", busy_fall_cyc, err_cyc + 1);
      end
   endtask

   task automatic test_timeout();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h12);
      wait_not_busy(INH + SETUP + EDGE_TO + 200);
      tick(2);
      $display("tx 12 no device clock, err after %0d cycles", err_cyc - release_cyc);
      vectors++;
      if (err_cyc - release_cyc !== EDGE_TO) begin
         miscompares++;
         $display("FAIL timeout_delay: %0d cycles, required %0d", err_cyc - release_cyc, EDGE_TO);
      end
      vectors++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
         miscompares++;
         $display("FAIL timeout_pulses: done=%0d err=%0d, required 0 1", done_cnt - d0, err_cnt - e0);
      end
      vectors++;
      if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL timeout_release: c_oe=%b d_oe=%b busy=%b, required 0 0 0",
                  ps2c_oe, ps2d_oe, busy);
      end
   endtask

   task automatic test_busy_reset();
      logic [10:0] bits;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h55);
      device_frame(1'b1, 11, 5, bits);
      wait_not_busy(500);
      tick(2);
      $display("tx 55 with AA poked mid-frame, frame=%b", bits);
      vectors++;
      if (bits !== 11'h6AA) begin
         miscompares++;
         $display("FAIL busy_frame_55: %b, required %b", bits, 11'h6AA);
      end
      tick(300);
      vectors++;
      if (busy !== 1'b0 || ps2c_oe !== 1'b0 || done_cnt - d0 !== 1) begin
         miscompares++;
         $display("FAIL busy_ignored: busy=%b c_oe=%b done=%0d, required 0 0 1",
                  busy, ps2c_oe, done_cnt - d0);
      end
      d0 = done_cnt; e0 = err_cnt;
      send_byte(8'h55);
      device_frame(1'b1, 4, 0, bits);
      vectors++;
      if (ps2d_oe !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_bit3: d_oe=%b busy=%b, required 1 1", ps2d_oe, busy);
      end
      rst = 1'b1;
      tick(1);
      vectors++;
      if ({ps2c_oe, ps2d_oe, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL mid_reset: c_oe=%b d_oe=%b busy=%b, required 0 0 0", ps2c_oe, ps2d_oe, busy);
      end
      rst = 1'b0;
      tick(200);
      $display("tx 55 aborted by reset after fall 4");
      vectors++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_pulse: done=%0d err=%0d busy=%b, required 0 0 0",
                  done_cnt - d0, err_cnt - e0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_back_to_back();
      test_nack();
      test_timeout();
      test_busy_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
